// File: rtl/des_round_ctrl_pkg.sv
// Shared types and constants for the DES round sequencer.
package des_round_ctrl_pkg;

  localparam int DW = 64;
  localparam int KW = 56;
  localparam logic [3:0] ROUND_LAST = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/des_round_ctrl_if.sv
// Request/result handshake bundle between the bus adapter (master) and the sequencer (slave).
interface des_round_ctrl_if
  import des_round_ctrl_pkg::*;
;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [KW-1:0] in_key;
  logic          in_decrypt;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  modport master (
    output in_valid, in_data, in_key, in_decrypt, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_key, in_decrypt, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/des_round_cnt.sv
// 4-bit round counter with synchronous clear/enable; wraps 15 -> 0 and flags the last round.
module des_round_cnt
  import des_round_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] cnt,
  output logic       last
);

  logic [3:0] cnt_r;

  // Round index register; natural 4-bit wrap returns it to 0 after the last round
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 4'd0;
    end else if (clr) begin
      cnt_r <= 4'd0;
    end else if (en) begin
      cnt_r <= cnt_r + 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt  = cnt_r;
  assign last = (cnt_r == ROUND_LAST);

endmodule

// File: rtl/des_round_ctrl.sv
// Initiator-side sequencer for the iterative DES round core.
// Optional: DES_ROUND_CTRL_KEY_CLR_EN zeroes core_key/core_desIn on entry to DONE.
module des_round_ctrl
  import des_round_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS = 16
) (
  input  logic           clk,
  input  logic           rst,
  des_round_ctrl_if.slave bus,
  output logic [DW-1:0]  core_desIn,
  output logic [KW-1:0]  core_key,
  output logic           core_decrypt,
  output logic [3:0]     core_roundSel,
  input  logic [DW-1:0]  core_desOut,
  output logic           busy
);

  if (NUM_ROUNDS != 16) begin : g_bad_rounds
    $error("des_round_ctrl: NUM_ROUNDS must be 16");
  end

  state_e        state_r;
  logic          in_ready_r;
  logic          out_valid_r;
  logic [DW-1:0] out_data_r;
  logic [DW-1:0] desin_r;
  logic [KW-1:0] key_r;
  logic          decrypt_r;
  logic          busy_r;

  logic          accept_s;
  logic          cnt_clr_s;
  logic          cnt_en_s;
  logic          rnd_last_s;
  logic [3:0]    rnd_s;

  // Request acceptance and round counter control
  always_comb begin
    accept_s  = 1'b0;
    cnt_clr_s = 1'b0;
    cnt_en_s  = 1'b0;
    case (state_r)
      IDLE: begin
        accept_s  = bus.in_valid & in_ready_r;
        cnt_clr_s = bus.in_valid & in_ready_r;
      end
      RUN: begin
        cnt_en_s = 1'b1;
      end
      DONE: begin
        cnt_en_s = 1'b0;
      end
      default: begin
        cnt_clr_s = 1'b1;
      end
    endcase
  end

  // The counter register drives core_roundSel directly, so it reads 0 outside RUN
  des_round_cnt u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr_s),
    .en   (cnt_en_s),
    .cnt  (rnd_s),
    .last (rnd_last_s)
  );

  // Sequencer FSM with holding registers and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= {DW{1'b0}};
      desin_r     <= {DW{1'b0}};
      key_r       <= {KW{1'b0}};
      decrypt_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            desin_r    <= bus.in_data;
            key_r      <= bus.in_key;
            decrypt_r  <= bus.in_decrypt;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= RUN;
          end
        end
        RUN: begin
          // The core output is combinational, so round 15's result is taken at the closing edge
          if (rnd_last_s) begin
            out_data_r  <= core_desOut;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
`ifdef DES_ROUND_CTRL_KEY_CLR_EN
            desin_r     <= {DW{1'b0}};
            key_r       <= {KW{1'b0}};
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign core_desIn    = desin_r;
  assign core_key      = key_r;
  assign core_decrypt  = decrypt_r;
  assign core_roundSel = rnd_s;
  assign busy          = busy_r;

endmodule

// File: tb/tb_des_round_ctrl.sv
// Randomized self-checking bench for des_round_ctrl with a 16-round Feistel stand-in core.
module tb_des_round_ctrl;

  logic        clk;
  logic        rst;
  logic [63:0] core_desIn;
  logic [55:0] core_key;
  logic        core_decrypt;
  logic [3:0]  core_roundSel;
  logic [63:0] core_desOut;
  logic        busy;

  int n_chk;
  int n_err;

  des_round_ctrl_if bus_if ();

  des_round_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus_if.slave),
    .core_desIn    (core_desIn),
    .core_key      (core_key),
    .core_decrypt  (core_decrypt),
    .core_roundSel (core_roundSel),
    .core_desOut   (core_desOut),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] subkey(input logic [55:0] k, input logic [3:0] i);
    logic [111:0] kk;
    kk = {k, k} >> (int'(i) * 3);
    return kk[31:0] ^ {28'd0, i};
  endfunction

  function automatic logic [63:0] fe(input logic [63:0] lr, input logic [31:0] sk);
    logic [31:0] t;
    t = lr[31:0] ^ sk;
    t = {t[26:0], t[31:27]} + (t ^ 32'h9E3779B9);
    return {lr[31:0], lr[63:32] ^ t};
  endfunction

  // Whole-block reference: 16 Feistel rounds, reversed key order for decrypt, final swap
  function automatic logic [63:0] ref_des(input logic [63:0] d, input logic [55:0] k, input logic dec);
    logic [63:0] lr;
    lr = d;
    for (int i = 0; i < 16; i++) begin
      lr = fe(lr, subkey(k, dec ? 4'(15 - i) : 4'(i)));
    end
    return {lr[31:0], lr[63:32]};
  endfunction

  // Stand-in core: unreset L/R state reloaded from desIn on round 0, combinational output
  logic [63:0] core_lr, core_src, core_nxt;
  always_comb begin
    core_src    = (core_roundSel == 4'd0) ? core_desIn : core_lr;
    core_nxt    = fe(core_src, subkey(core_key, core_decrypt ? 4'd15 - core_roundSel : core_roundSel));
    core_desOut = {core_nxt[31:0], core_nxt[63:32]};
  end
  always_ff @(posedge clk) core_lr <= core_nxt;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One block: accept, 16 rounds, optional injected request / reset, backpressure, drain
  task automatic run_block(input logic [63:0] d, input logic [55:0] k, input logic dec,
                           input int inj_rnd, input int rst_rnd, input int bp,
                           input bit done_req, output logic [63:0] res);
    logic [63:0] exp;
    exp = ref_des(d, k, dec);
    res = 64'd0;
    @(negedge clk);
    chk("idle_in_ready", 64'(bus_if.in_ready), 64'd1);
    bus_if.in_valid   = 1'b1;
    bus_if.in_data    = d;
    bus_if.in_key     = k;
    bus_if.in_decrypt = dec;
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = {$urandom, $urandom};
    for (int r = 0; r < 16; r++) begin
      if (r > 0) @(negedge clk);
      chk("round_sel", 64'(core_roundSel), 64'(r));
      chk("run_in_ready", 64'(bus_if.in_ready), 64'd0);
      chk("run_out_valid", 64'(bus_if.out_valid), 64'd0);
      chk("run_busy", 64'(busy), 64'd1);
      chk("hold_desin", core_desIn, d);
      chk("hold_key", 64'(core_key), 64'(k));
      chk("hold_decrypt", 64'(core_decrypt), 64'(dec));
      if (r == rst_rnd) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_in_ready", 64'(bus_if.in_ready), 64'd1);
        chk("mid_rst_out_valid", 64'(bus_if.out_valid), 64'd0);
        chk("mid_rst_round_sel", 64'(core_roundSel), 64'd0);
        chk("mid_rst_out_data", bus_if.out_data, 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_desin", core_desIn, 64'd0);
        bus_if.out_ready = 1'b0;
        return;
      end
      if (r == inj_rnd) begin
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = ~d;
        bus_if.in_key   = ~k;
      end else begin
        bus_if.in_valid = 1'b0;
      end
      bus_if.out_ready = 1'($urandom_range(0, 1));
    end
    bus_if.out_ready = 1'b0;
    @(negedge clk);
    chk("done_out_valid", 64'(bus_if.out_valid), 64'd1);
    chk("done_out_data", bus_if.out_data, exp);
    chk("done_in_ready", 64'(bus_if.in_ready), 64'd0);
    chk("done_round_sel", 64'(core_roundSel), 64'd0);
    chk("done_busy", 64'(busy), 64'd1);
`ifdef DES_ROUND_CTRL_KEY_CLR_EN
    chk("done_key_clr", 64'(core_key), 64'd0);
    chk("done_desin_clr", core_desIn, 64'd0);
`else
    chk("done_key_held", 64'(core_key), 64'(k));
    chk("done_desin_held", core_desIn, d);
`endif
    res = bus_if.out_data;
    for (int i = 0; i < bp; i++) begin
      bus_if.in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("bp_out_valid", 64'(bus_if.out_valid), 64'd1);
      chk("bp_out_data", bus_if.out_data, exp);
      chk("bp_in_ready", 64'(bus_if.in_ready), 64'd0);
    end
    bus_if.in_valid  = done_req;
    bus_if.in_data   = {$urandom, $urandom};
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    bus_if.out_ready = 1'b0;
    bus_if.in_valid  = 1'b0;
    chk("drain_out_valid", 64'(bus_if.out_valid), 64'd0);
    chk("drain_in_ready", 64'(bus_if.in_ready), 64'd1);
    chk("drain_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ct, pt, res;
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    bus_if.in_valid   = 1'b0;
    bus_if.in_data    = 64'd0;
    bus_if.in_key     = 56'd0;
    bus_if.in_decrypt = 1'b0;
    bus_if.out_ready  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(bus_if.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
    chk("rst_out_data", bus_if.out_data, 64'd0);
    chk("rst_round_sel", 64'(core_roundSel), 64'd0);
    chk("rst_desin", core_desIn, 64'd0);
    chk("rst_key", 64'(core_key), 64'd0);
    chk("rst_decrypt", 64'(core_decrypt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;

    run_block(64'h0123456789ABCDEF, 56'h00000000000000, 1'b0, -1, -1, 5, 1'b0, ct);
    run_block(ct, 56'h00000000000000, 1'b1, -1, -1, 0, 1'b1, pt);
    chk("round_trip", pt, 64'h0123456789ABCDEF);

    run_block({$urandom, $urandom}, {24'($urandom), $urandom}, 1'b0, 4, -1, 1, 1'b0, res);
    run_block({$urandom, $urandom}, {24'($urandom), $urandom}, 1'b1, -1, 7, 0, 1'b0, res);
    run_block({$urandom, $urandom}, {24'($urandom), $urandom}, 1'b0, -1, -1, 2, 1'b1, res);

    for (int n = 0; n < 6; n++) begin
      run_block({$urandom, $urandom}, {24'($urandom), $urandom}, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 20)), -1, int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), res);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/des_round_ctrl.md
Name: des_round_ctrl

Overview:
Initiator-side sequencer for the iterative DES round datapath. The datapath exposes desIn/key/decrypt/roundSel and returns a combinational desOut.
- Accepts one 64-bit block plus 56-bit key and direction over a valid/ready handshake.
- Registers and holds the core inputs, drives roundSel 0..15 over 16 cycles, and captures desOut on the last round.
- Returns the result over a second valid/ready handshake.
- Sits between the system bus adapter and the DES core.

Parameters:
NUM_ROUNDS, 16, rounds per block; only 16 is legal; elaboration check fails otherwise.
DW, 64, block width.
KW, 56, key width (parity bits already stripped).

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  request valid.
in_ready  output  1  request accepted when in_valid & in_ready.
in_data  input  DW  plaintext/ciphertext block.
in_key  input  KW  key.
in_decrypt  input  1  1 = decrypt, 0 = encrypt.
out_valid  output  1  result valid.
out_ready  input  1  result consumed when out_valid & out_ready.
out_data  output  DW  result block.
core_desIn  output  DW  to core desIn.
core_key  output  KW  to core key.
core_decrypt  output  1  to core decrypt.
core_roundSel  output  4  to core roundSel.
core_desOut  input  DW  from core desOut (combinational in core).
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst=1 at edge), all outputs registered:
  - state=IDLE; in_ready=1; out_valid=0; out_data=0.
  - core_roundSel=0; core_desIn=0; core_key=0; core_decrypt=0; busy=0.
  - rst overrides all other inputs, including mid-RUN and mid-DONE; any in-flight block is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On accept: latch in_data->core_desIn, in_key->core_key, in_decrypt->core_decrypt; set round counter rnd=0; go to RUN.
- RUN:
  - core_roundSel=rnd; in_ready=0.
  - core_desIn/core_key/core_decrypt held constant for all 16 cycles.
  - rnd increments each cycle.
  - In the cycle with rnd=15, out_data<=core_desOut at the closing edge; state->DONE; rnd wraps to 0.
- DONE:
  - out_valid=1; out_data stable; core_roundSel=0.
  - On out_ready: out_valid->0, state->IDLE, in_ready->1 next cycle.
- Latency: out_valid rises on the 16th rising edge after the accepting edge.
- Throughput: at most one block per 18 cycles, since in_ready is low during DONE.
- in_valid during RUN/DONE is ignored; no request is dropped because in_ready=0.
- out_ready while out_valid=0 has no effect.
- Simultaneous in_valid and out_ready in DONE: only the result handshake completes; the request waits for IDLE.
- The core's L/R registers are not reset; correctness relies on round 0 reloading from IP(desIn).

Optional Feature:
Macro DES_ROUND_CTRL_KEY_CLR_EN.
- Defined: core_key and core_desIn are zeroed on the edge that enters DONE, so key material is not left on core inputs while the result waits.
- Undefined: both hold their last values until the next accept.
- out_data is identical in both cases.

Decomposition:
- Package des_round_ctrl_pkg: state enum (IDLE, RUN, DONE), ROUND_LAST = 4'd15, DW/KW localparams.
- One natural sub-module, des_round_cnt: 4-bit counter with clear/enable and a last flag.
- The FSM and holding registers stay in the top.

Test Plan:
- Round sequence: accept block at edge 0 -> core_roundSel = 0,1,...,15 on consecutive cycles; in_ready=0 throughout; out_valid=1 after edge 16.
- Round trip with real DES core: encrypt in_data=64'h0123456789ABCDEF, in_key=56'h00000000000000, then decrypt the result with the same key -> out_data=64'h0123456789ABCDEF.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_data constant, out_valid=1, in_ready=0; out_ready=1 -> out_valid=0 and in_ready=1 the next cycle.
- Reset mid-operation: assert rst while core_roundSel=7 -> next cycle state IDLE, in_ready=1, out_valid=0, core_roundSel=0, out_data=0. A fresh block then completes correctly.
- Ignored request: pulse in_valid with new data at round 4 -> core_desIn unchanged and result matches the original block.
- Macro on: after entering DONE -> core_key=0 and core_desIn=0, with out_data unchanged. Macro off: core_key retains 56'h00000000000000 or the key last used.
